// File: rtl/vsmac_pkg.sv
// vsmac_pkg: state encoding and default geometry shared by the vsmac and its sequencer
package vsmac_pkg;
  localparam int VSMAC_SIZE = 6;
  localparam int VSMAC_WIDTH = 8;
  localparam int VSMAC_ACCUMULATIONS = 3;
  localparam int VSMAC_DRAIN_CYCLES = 2;
  typedef enum logic [1:0] {CLEAR, FEED, DRAIN, HOLD} seq_state_e;
endpackage

// File: rtl/vsmac_sequencer_if.sv
// vsmac_sequencer_if: operand stream, vsmac drive and result stream of the sequencer
interface vsmac_sequencer_if
  import vsmac_pkg::*;
#(
  parameter int SIZE = VSMAC_SIZE,
  parameter int WIDTH = VSMAC_WIDTH
);
  logic [WIDTH*SIZE-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic in_valid;
  logic in_ready;
  logic mac_clear;
  logic mac_enable;
  logic [WIDTH*SIZE-1:0] mac_a;
  logic [WIDTH-1:0] mac_b;
  logic [WIDTH*SIZE-1:0] mac_out;
  logic [WIDTH*SIZE-1:0] res_data;
  logic res_valid;
  logic res_ready;
  modport master (
    output in_a, in_b, in_valid, mac_out, res_ready,
    input in_ready, mac_clear, mac_enable, mac_a, mac_b, res_data, res_valid
  );
  modport slave (
    input in_a, in_b, in_valid, mac_out, res_ready,
    output in_ready, mac_clear, mac_enable, mac_a, mac_b, res_data, res_valid
  );
endinterface

// File: rtl/vsmac_sequencer.sv
// vsmac_sequencer: clears the vsmac, feeds it ACCUMULATIONS operand pairs, then returns its result
module vsmac_sequencer
  import vsmac_pkg::*;
#(
  parameter int SIZE = VSMAC_SIZE,
  parameter int WIDTH = VSMAC_WIDTH,
  parameter int ACCUMULATIONS = VSMAC_ACCUMULATIONS,
  parameter int DRAIN_CYCLES = VSMAC_DRAIN_CYCLES
) (
  input logic clk,
  input logic reset_n,
  vsmac_sequencer_if.slave bus
);
  localparam int VW = WIDTH * SIZE;
  localparam int AW = $clog2(ACCUMULATIONS + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] ACC_LAST = AW'(ACCUMULATIONS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  seq_state_e state;
  logic [AW-1:0] acc_cnt;
  logic [DW-1:0] drain_cnt;
  logic take;
  assign take = bus.in_valid & bus.in_ready;
  // job FSM; drain counting waits out the final mac_enable cycle before it starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      acc_cnt <= '0;
      drain_cnt <= '0;
      bus.in_ready <= 1'b0;
      bus.mac_clear <= 1'b1;
      bus.mac_enable <= 1'b0;
      bus.mac_a <= {VW{1'b0}};
      bus.mac_b <= {WIDTH{1'b0}};
      bus.res_data <= {VW{1'b0}};
      bus.res_valid <= 1'b0;
    end else begin
      bus.mac_enable <= take;
      case (state)
        CLEAR: begin
          state <= FEED;
          acc_cnt <= '0;
          drain_cnt <= '0;
          bus.mac_clear <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        FEED: if (take) begin
          bus.mac_a <= bus.in_a;
          bus.mac_b <= bus.in_b;
          acc_cnt <= acc_cnt + 1'b1;
          if (acc_cnt == ACC_LAST) begin
            state <= DRAIN;
            bus.in_ready <= 1'b0;
          end
        end
        DRAIN: if (!bus.mac_enable) begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= HOLD;
            drain_cnt <= '0;
            bus.res_data <= bus.mac_out;
            bus.res_valid <= 1'b1;
          end else drain_cnt <= drain_cnt + 1'b1;
        end
        default: if (bus.res_ready) begin
          state <= CLEAR;
          bus.res_valid <= 1'b0;
          bus.mac_clear <= 1'b1;
        end
      endcase
    end
  end
endmodule
